// File: rtl/proj1_pkg.sv
// Shared constants and FSM encoding for the proj1 counter scheduler.
package proj1_pkg;

  localparam int DATABIT_DEF = 7;

  localparam int IDLE_B = 0;
  localparam int RUN_B  = 1;
  localparam int DONE_B = 2;

  // One-hot so each state decodes from a single flop.
  typedef enum logic [2:0] {
    S_IDLE      = 3'b001,
    S_WAIT_RUN  = 3'b010,
    S_WAIT_DONE = 3'b100
  } state_t;

endpackage

// File: rtl/proj1_sync_fifo.sv
// Small synchronous FIFO; flags come from registered pointers only.
module proj1_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB tells full from empty when the indexes match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/proj1_cnt_sched.sv
// Job scheduler: queues count requests and issues them one at a time
// to the counter core, with start timeout and completed-job count.
module proj1_cnt_sched
  import proj1_pkg::*;
#(
  parameter int DATABIT  = DATABIT_DEF,
  parameter int DEPTH    = 4,
  parameter int START_TO = 8,
  parameter int JOBW     = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATABIT-1:0]     s_num_cnt,
  output logic                   o_run,
  output logic [DATABIT-1:0]     o_num_cnt,
  input  logic                   i_idle,
  input  logic                   i_running,
  input  logic                   i_done,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_drop,
  output logic                   o_timeout,
  output logic                   o_job_done,
  output logic [JOBW-1:0]        o_job_cnt
);

  localparam int TW = $clog2(START_TO + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TO - 1);

  state_t            state;
  state_t            state_nxt;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_nxt;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              run_nxt;
  logic              timeout_nxt;
  logic              done_nxt;
  logic [DATABIT-1:0] fifo_dout;

  assign s_ready = !full;
  assign accept  = s_valid && s_ready;
  assign push    = accept && (s_num_cnt != '0);
  assign o_busy  = (state != S_IDLE);

  proj1_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATABIT)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (s_num_cnt),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (full),
    .empty   (empty),
    .level   (o_level)
  );

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    pop         = 1'b0;
    run_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    done_nxt    = 1'b0;
    unique case (1'b1)
      state[IDLE_B]: begin
        if (!empty && i_idle) begin
          pop       = 1'b1;
          run_nxt   = 1'b1;
          timer_nxt = '0;
          state_nxt = S_WAIT_RUN;
        end
      end
      state[RUN_B]: begin
        // A done seen before running still completes the job.
        if (i_done) begin
          done_nxt  = 1'b1;
          timer_nxt = '0;
          state_nxt = S_IDLE;
        end else if (i_running) begin
          timer_nxt = '0;
          state_nxt = S_WAIT_DONE;
        end else if (timer == TO_LAST) begin
          timeout_nxt = 1'b1;
          timer_nxt   = '0;
          state_nxt   = S_IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      state[DONE_B]: begin
        if (i_done) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        timer_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      o_run      <= 1'b0;
      o_num_cnt  <= '0;
      o_drop     <= 1'b0;
      o_timeout  <= 1'b0;
      o_job_done <= 1'b0;
      o_job_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      o_run      <= run_nxt;
      o_drop     <= accept && (s_num_cnt == '0);
      o_timeout  <= timeout_nxt;
      o_job_done <= done_nxt;
      o_job_cnt  <= o_job_cnt + JOBW'(done_nxt);
      if (pop) o_num_cnt <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_proj1_cnt_sched.sv
// Directed bench for proj1_cnt_sched with hand-computed expectations.
module tb_proj1_cnt_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_valid;
  logic       s_ready;
  logic [6:0] s_num_cnt;
  logic       o_run;
  logic [6:0] o_num_cnt;
  logic       i_idle;
  logic       i_running;
  logic       i_done;
  logic       o_busy;
  logic [2:0] o_level;
  logic       o_drop;
  logic       o_timeout;
  logic       o_job_done;
  logic [7:0] o_job_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  proj1_cnt_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_num_cnt  (s_num_cnt),
    .o_run      (o_run),
    .o_num_cnt  (o_num_cnt),
    .i_idle     (i_idle),
    .i_running  (i_running),
    .i_done     (i_done),
    .o_busy     (o_busy),
    .o_level    (o_level),
    .o_drop     (o_drop),
    .o_timeout  (o_timeout),
    .o_job_done (o_job_done),
    .o_job_cnt  (o_job_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] n);
    s_valid   = 1'b1;
    s_num_cnt = n;
    tick;
    s_valid   = 1'b0;
  endtask

  task automatic run_job(input logic [6:0] exp);
    i_idle = 1'b1;
    tick;
    chk("run", o_run, 1);
    chk("num", o_num_cnt, exp);
    i_idle    = 1'b0;
    i_running = 1'b1;
    tick;
    chk("run_once", o_run, 0);
    i_running = 1'b0;
    i_done    = 1'b1;
    tick;
    chk("job_done", o_job_done, 1);
    i_done = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    s_valid   = 1'b0;
    s_num_cnt = '0;
    i_idle    = 1'b1;
    i_running = 1'b0;
    i_done    = 1'b0;
    #12;
    chk("rst_ready", s_ready, 1);
    chk("rst_level", o_level, 0);
    chk("rst_run", o_run, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_num", o_num_cnt, 0);
    chk("rst_jobs", o_job_cnt, 0);
    tick;
    reset_n = 1'b1;
    tick;

    // 1: single job, run pulse two cycles after accept
    push(7'd5);
    chk("t1_level", o_level, 1);
    chk("t1_norun", o_run, 0);
    tick;
    chk("t1_run", o_run, 1);
    chk("t1_num", o_num_cnt, 5);
    chk("t1_busy", o_busy, 1);
    chk("t1_level0", o_level, 0);
    i_idle    = 1'b0;
    i_running = 1'b1;
    tick;
    chk("t1_run_off", o_run, 0);
    i_running = 1'b0;
    i_done    = 1'b1;
    tick;
    chk("t1_done", o_job_done, 1);
    chk("t1_cnt", o_job_cnt, 1);
    chk("t1_idle", o_busy, 0);
    i_done = 1'b0;
    i_idle = 1'b1;
    tick;
    chk("t1_done_off", o_job_done, 0);

    // 2: zero-length request is dropped
    push(7'd0);
    chk("t2_drop", o_drop, 1);
    chk("t2_level", o_level, 0);
    tick;
    chk("t2_drop_off", o_drop, 0);
    chk("t2_norun", o_run, 0);
    tick;
    chk("t2_norun2", o_run, 0);
    chk("t2_busy", o_busy, 0);

    // 3: fill with counter busy, stall, drain in order
    i_idle = 1'b0;
    push(7'd3);
    push(7'd4);
    push(7'd6);
    push(7'd7);
    chk("t3_level", o_level, 4);
    chk("t3_full", s_ready, 0);
    s_valid   = 1'b1;
    s_num_cnt = 7'd9;
    tick;
    tick;
    chk("t3_stall_lvl", o_level, 4);
    chk("t3_stall_rdy", s_ready, 0);
    s_valid = 1'b0;
    run_job(7'd3);
    run_job(7'd4);
    run_job(7'd6);
    run_job(7'd7);
    chk("t3_cnt", o_job_cnt, 5);
    chk("t3_empty", o_level, 0);

    // 4: start timeout, then next entry issues
    push(7'd10);
    push(7'd11);
    i_idle = 1'b1;
    tick;
    chk("t4_run", o_run, 1);
    chk("t4_num", o_num_cnt, 10);
    i_idle = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick;
      chk("t4_wait_to", o_timeout, 0);
      chk("t4_wait_busy", o_busy, 1);
    end
    i_idle = 1'b1;
    tick;
    chk("t4_timeout", o_timeout, 1);
    chk("t4_idle", o_busy, 0);
    chk("t4_cnt", o_job_cnt, 5);
    tick;
    chk("t4_to_off", o_timeout, 0);
    chk("t4_run2", o_run, 1);
    chk("t4_num2", o_num_cnt, 11);
    i_idle = 1'b0;
    i_done = 1'b1;
    tick;
    chk("t4_done_wr", o_job_done, 1);
    chk("t4_cnt2", o_job_cnt, 6);
    i_done = 1'b0;

    // 5: push and pop together, then counter wrap
    push(7'd1);
    push(7'd2);
    chk("t5_level2", o_level, 2);
    i_idle    = 1'b1;
    s_valid   = 1'b1;
    s_num_cnt = 7'd3;
    tick;
    s_valid = 1'b0;
    i_idle  = 1'b0;
    chk("t5_level_same", o_level, 2);
    chk("t5_run", o_run, 1);
    chk("t5_num", o_num_cnt, 1);
    i_done = 1'b1;
    tick;
    i_done = 1'b0;
    chk("t5_cnt7", o_job_cnt, 7);
    run_job(7'd2);
    run_job(7'd3);
    chk("t5_cnt9", o_job_cnt, 9);
    for (int j = 9; j < 255; j++) begin
      push(7'(j % 100 + 1));
      run_job(7'(j % 100 + 1));
    end
    chk("t5_cnt255", o_job_cnt, 255);
    push(7'd5);
    run_job(7'd5);
    chk("t5_wrap", o_job_cnt, 0);

    // 6: reset while in WAIT_DONE with three queued
    push(7'd20);
    push(7'd21);
    push(7'd22);
    push(7'd23);
    i_idle = 1'b1;
    tick;
    i_idle    = 1'b0;
    i_running = 1'b1;
    tick;
    i_running = 1'b0;
    chk("t6_busy", o_busy, 1);
    chk("t6_level", o_level, 3);
    reset_n = 1'b0;
    #1;
    chk("t6_level0", o_level, 0);
    chk("t6_ready", s_ready, 1);
    chk("t6_idle", o_busy, 0);
    chk("t6_run", o_run, 0);
    chk("t6_num", o_num_cnt, 0);
    chk("t6_jobs", o_job_cnt, 0);
    i_done = 1'b1;
    tick;
    chk("t6_no_done", o_job_done, 0);
    chk("t6_no_to", o_timeout, 0);
    chk("t6_no_drop", o_drop, 0);
    i_done  = 1'b0;
    i_idle  = 1'b1;
    reset_n = 1'b1;
    tick;
    tick;
    chk("t6_post_run", o_run, 0);
    chk("t6_post_lvl", o_level, 0);
    chk("t6_post_busy", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
